lcd_num_display: RTL and testbench

//  Parametrised HD44780-class character-LCD driver for calculator results. Runs power-up init once,

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_bin2dec.sv | 96 +++++++++
 rtl/lcd_num_display.sv | 259 +++++++++++++++++++++++++
 tb/tb_lcd_num_display.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the calculator character-LCD driver.
// HD44780 command bytes, the ASCII characters used in fields, and FSM/sequencer states.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_HASH  = 8'h23;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT, IDLE, LATCH, CONVERT, ADDR, CHARS, NEXT, DONE
  } state_t;

  typedef enum logic [1:0] {
    WR_IDLE, WR_SU, WR_EH, WR_WAIT
  } wr_phase_t;

  // Decimal digits needed for the largest unsigned w-bit magnitude.
  function automatic int num_digits(input int w);
    logic [63:0] v;
    int d;
    v = (64'd1 << w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/lcd_bin2dec.sv
// Sequential restoring divide-by-10: emits one decimal digit per DATA_W cycles, LSB digit first.
// Always runs NUM_DIGITS passes so conversion time does not depend on the value.
module lcd_bin2dec #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mag,
  output logic [3:0]        digit,
  output logic              digit_vld,
  output logic              last
);

  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(NUM_DIGITS + 1);

  logic              run_q, run_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [3:0]        rem_q, rem_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic [3:0]        digit_q, digit_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;

  logic [4:0]        trial;
  logic              ge;
  logic [3:0]        rem_nx;
  logic [DATA_W-1:0] quo_nx;

  assign trial  = {rem_q, work_q[DATA_W-1]};
  assign ge     = (trial >= 5'd10);
  assign rem_nx = ge ? 4'(trial - 5'd10) : trial[3:0];
  assign quo_nx = {work_q[DATA_W-2:0], ge};

  always_comb begin
    run_d   = run_q;
    work_d  = work_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    dig_d   = dig_q;
    digit_d = digit_q;
    vld_d   = 1'b0;
    last_d  = last_q;
    if (start) begin
      run_d  = 1'b1;
      work_d = mag;
      rem_d  = '0;
      bit_d  = '0;
      dig_d  = '0;
    end else if (run_q) begin
      work_d = quo_nx;
      rem_d  = rem_nx;
      bit_d  = bit_q + 1'b1;
      // The quotient stays in work_q and becomes the next pass's dividend.
      if (bit_q == BW'(DATA_W - 1)) begin
        digit_d = rem_nx;
        vld_d   = 1'b1;
        last_d  = (quo_nx == '0);
        rem_d   = '0;
        bit_d   = '0;
        dig_d   = dig_q + 1'b1;
        if (dig_q == DW'(NUM_DIGITS - 1)) run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      work_q  <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      dig_q   <= '0;
      digit_q <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
      dig_q   <= dig_d;
      digit_q <= digit_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign digit     = digit_q;
  assign digit_vld = vld_q;
  assign last      = last_q;

endmodule

// File: rtl/lcd_num_display.sv
// HD44780 driver that shows one or two signed integers right-justified in fixed-width fields.
// Runs power-up init once, then redraws both lines on each accepted start request.
module lcd_num_display
  import lcd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FIELD_W   = 11,
  parameter int NUM_LINES = 2,
  parameter int T_PWR     = 750000,
  parameter int T_SU      = 2,
  parameter int T_EH      = 12,
  parameter int T_CMD     = 2000,
  parameter int T_CLR     = 80000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] value_a,
  input  logic [DATA_W-1:0] value_b,
  output logic              busy,
  output logic              done,
  output logic [7:0]        lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e
);

  localparam int NUM_DIGITS = num_digits(DATA_W);
  localparam int CW         = $clog2(FIELD_W);

  state_t            state_q, state_d;
  wr_phase_t         wr_ph_q, wr_ph_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [1:0]        init_idx_q, init_idx_d;
  logic [CW-1:0]     chr_idx_q, chr_idx_d;
  logic              line_q, line_d;
  logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
  logic              neg_q, neg_d;
  logic              seen_last_q, seen_last_d;
  logic [7:0]        ndig_q, ndig_d, dig_cnt_q, dig_cnt_d;
  logic [7:0]        buf_q [FIELD_W];
  logic [7:0]        buf_d [FIELD_W];
  logic [7:0]        data_q, data_d;
  logic              rs_q, rs_d, e_q, e_d;

  logic              conv_start, wr_fin;
  logic [DATA_W-1:0] sel_val, conv_mag;
  logic [3:0]        digit;
  logic              digit_vld, last;
  logic [31:0]       wait_last;
  logic [7:0]        init_cmd;

  assign sel_val   = (state_q == NEXT) ? val_b_q : val_a_q;
  assign conv_mag  = sel_val[DATA_W-1] ? (~sel_val + DATA_W'(1)) : sel_val;
  assign wait_last = (!rs_q && data_q == LCD_CLEAR) ? 32'(T_CLR - 1) : 32'(T_CMD - 1);

  lcd_bin2dec #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2dec (
    .clk      (clk),
    .rst      (rst),
    .start    (conv_start),
    .mag      (conv_mag),
    .digit    (digit),
    .digit_vld(digit_vld),
    .last     (last)
  );

  always_comb begin
    case (init_idx_q)
      2'd0:    init_cmd = LCD_FUNC_SET;
      2'd1:    init_cmd = LCD_DISP_ON;
      2'd2:    init_cmd = LCD_ENTRY;
      default: init_cmd = LCD_CLEAR;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_ph_d     = wr_ph_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    chr_idx_d   = chr_idx_q;
    line_d      = line_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    neg_d       = neg_q;
    seen_last_d = seen_last_q;
    ndig_d      = ndig_q;
    dig_cnt_d   = dig_cnt_q;
    buf_d       = buf_q;
    data_d      = data_q;
    rs_d        = rs_q;
    e_d         = e_q;
    conv_start  = 1'b0;
    wr_fin      = 1'b0;

    // Write cycle: data settles, enable pulses, then the LCD gets its execution time.
    case (wr_ph_q)
      WR_SU: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(T_SU - 1)) begin
          wr_ph_d = WR_EH;
          cnt_d   = '0;
          e_d     = 1'b1;
        end
      end
      WR_EH: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(T_EH - 1)) begin
          wr_ph_d = WR_WAIT;
          cnt_d   = '0;
          e_d     = 1'b0;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == wait_last) begin
          wr_ph_d = WR_IDLE;
          cnt_d   = '0;
          wr_fin  = 1'b1;
        end
      end
      default: ;
    endcase

    case (state_q)
      PWR_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(T_PWR - 1)) begin
          cnt_d      = '0;
          init_idx_d = '0;
          state_d    = INIT;
        end
      end
      INIT: begin
        if (wr_ph_q == WR_IDLE) begin
          data_d  = init_cmd;
          rs_d    = 1'b0;
          wr_ph_d = WR_SU;
          cnt_d   = '0;
        end else if (wr_fin) begin
          init_idx_d = init_idx_q + 2'd1;
          if (init_idx_q == 2'd3) state_d = IDLE;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          val_a_d = value_a;
          val_b_d = value_b;
          line_d  = 1'b0;
          state_d = LATCH;
        end
      end
      LATCH, NEXT: begin
        conv_start  = 1'b1;
        line_d      = (state_q == NEXT);
        neg_d       = sel_val[DATA_W-1];
        seen_last_d = 1'b0;
        ndig_d      = '0;
        dig_cnt_d   = '0;
        for (int i = 0; i < FIELD_W; i++) buf_d[i] = ASCII_SPACE;
        state_d = CONVERT;
      end
      CONVERT: begin
        // Digits after the first 'last' are leading zeros and are dropped.
        if (digit_vld) begin
          dig_cnt_d = dig_cnt_q + 8'd1;
          if (!seen_last_q) begin
            if (int'(dig_cnt_q) < FIELD_W)
              buf_d[CW'(FIELD_W - 1 - int'(dig_cnt_q))] = ASCII_ZERO + {4'd0, digit};
            if (last) begin
              seen_last_d = 1'b1;
              ndig_d      = dig_cnt_q + 8'd1;
            end
          end
          if (dig_cnt_q == 8'(NUM_DIGITS - 1)) state_d = ADDR;
        end
      end
      ADDR: begin
        if (wr_ph_q == WR_IDLE) begin
          data_d  = line_q ? LCD_LINE2 : LCD_LINE1;
          rs_d    = 1'b0;
          wr_ph_d = WR_SU;
          cnt_d   = '0;
          if (int'(ndig_q) + int'(neg_q) > FIELD_W) begin
            for (int i = 0; i < FIELD_W; i++) buf_d[i] = ASCII_HASH;
          end else if (neg_q) begin
            buf_d[CW'(FIELD_W - 1 - int'(ndig_q))] = ASCII_MINUS;
          end
        end else if (wr_fin) begin
          chr_idx_d = '0;
          state_d   = CHARS;
        end
      end
      CHARS: begin
        if (wr_ph_q == WR_IDLE) begin
          data_d  = buf_q[chr_idx_q];
          rs_d    = 1'b1;
          wr_ph_d = WR_SU;
          cnt_d   = '0;
        end else if (wr_fin) begin
          chr_idx_d = chr_idx_q + 1'b1;
          if (chr_idx_q == CW'(FIELD_W - 1))
            state_d = (NUM_LINES == 2 && !line_q) ? NEXT : DONE;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      wr_ph_q     <= WR_IDLE;
      cnt_q       <= '0;
      init_idx_q  <= '0;
      chr_idx_q   <= '0;
      line_q      <= 1'b0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      neg_q       <= 1'b0;
      seen_last_q <= 1'b0;
      ndig_q      <= '0;
      dig_cnt_q   <= '0;
      for (int i = 0; i < FIELD_W; i++) buf_q[i] <= ASCII_SPACE;
      data_q      <= '0;
      rs_q        <= 1'b0;
      e_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ph_q     <= wr_ph_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      chr_idx_q   <= chr_idx_d;
      line_q      <= line_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      neg_q       <= neg_d;
      seen_last_q <= seen_last_d;
      ndig_q      <= ndig_d;
      dig_cnt_q   <= dig_cnt_d;
      buf_q       <= buf_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      e_q         <= e_d;
    end
  end

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;

endmodule

// File: tb/tb_lcd_num_display.sv
// Self-checking bench: an LCD model logs {rs,data} on every falling lcd_e and is compared
// against hand-computed init sequences and field contents for two driver configurations.
module tb_lcd_num_display;

  localparam int CLK_PER = 10;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic [31:0] value_a, value_b, value_a2, value_b2;
  logic        busy, done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0]  lcd_data;
  logic        busy2, done2, lcd_rs2, lcd_rw2, lcd_e2;
  logic [7:0]  lcd_data2;

  logic [8:0]  log1 [$];
  logic [8:0]  log2 [$];
  int          done_cnt = 0;
  int          done_cnt2 = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    string       l1;
    string       l2;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    string       l1;
  } vec2_t;

  vec_t  vecs [4];
  vec2_t vecs2 [6];

  always #(CLK_PER / 2) clk = ~clk;

  lcd_num_display #(
    .DATA_W(32), .FIELD_W(11), .NUM_LINES(2),
    .T_PWR(20), .T_SU(1), .T_EH(2), .T_CMD(4), .T_CLR(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .value_a(value_a), .value_b(value_b),
    .busy(busy), .done(done), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  lcd_num_display #(
    .DATA_W(32), .FIELD_W(4), .NUM_LINES(1),
    .T_PWR(20), .T_SU(1), .T_EH(2), .T_CMD(4), .T_CLR(10)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .value_a(value_a2), .value_b(value_b2),
    .busy(busy2), .done(done2), .lcd_data(lcd_data2), .lcd_rs(lcd_rs2), .lcd_rw(lcd_rw2), .lcd_e(lcd_e2)
  );

  // LCD models latch the bus when the enable strobe falls.
  always @(negedge lcd_e)  if (!rst) log1.push_back({lcd_rs, lcd_data});
  always @(negedge lcd_e2) if (!rst) log2.push_back({lcd_rs2, lcd_data2});

  always @(negedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done2) done_cnt2 <= done_cnt2 + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic checkText(input string name, input string got, input string exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
  endtask

  function automatic logic [8:0] entryAt(input logic [8:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 9'h1FF;
  endfunction

  // Characters written with rs=1; a command or a missing entry shows as '!' or '?'.
  function automatic string lineText(input logic [8:0] q [$], input int base, input int n);
    string s;
    logic [8:0] ent;
    s = "";
    for (int i = 0; i < n; i++) begin
      if (base + i >= q.size()) s = {s, "?"};
      else begin
        ent = q[base + i];
        if (ent[8] !== 1'b1) s = {s, "!"};
        else s = $sformatf("%s%c", s, ent[7:0]);
      end
    end
    return s;
  endfunction

  task automatic waitIdle(input bit sel, input int limit, input string name);
    int n;
    n = 0;
    while (((sel ? busy2 : busy) !== 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " busy low in time"}, 32'(sel ? busy2 : busy), 32'd0);
  endtask

  task automatic applyStimulus(input bit sel, input logic [31:0] a, input logic [31:0] b,
                               output int lbase, output int dbase);
    int n;
    waitIdle(sel, 3000, "pre-start");
    @(negedge clk);
    lbase = sel ? log2.size() : log1.size();
    dbase = sel ? done_cnt2 : done_cnt;
    if (sel) begin value_a2 = a; value_b2 = b; start2 = 1'b1; end
    else     begin value_a  = a; value_b  = b; start  = 1'b1; end
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
    n = 0;
    while (((sel ? done_cnt2 : done_cnt) == dbase) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total_cnt++;
      $display("[TB] FAIL done timeout: got no done pulse after %0d cycles, expected one", n);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic checkUpdate(input string name, input int lbase, input int dbase,
                             input string l1, input string l2);
    checkOutput({name, " log size"}, 32'(log1.size() - lbase), 32'd24);
    checkOutput({name, " addr1"}, 32'(entryAt(log1, lbase)), 32'h080);
    checkText({name, " line1"}, lineText(log1, lbase + 1, 11), l1);
    checkOutput({name, " addr2"}, 32'(entryAt(log1, lbase + 12)), 32'h0C0);
    checkText({name, " line2"}, lineText(log1, lbase + 13, 11), l2);
    checkOutput({name, " done pulses"}, 32'(done_cnt - dbase), 32'd1);
  endtask

  // Init bytes in order, busy held through the clear wait, and the clear wait length.
  task automatic runInit(input string name, input int lbase, input int dbase);
    int n;
    time t_fall;
    n = 0;
    while (log1.size() - lbase < 4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    t_fall = $time;
    checkOutput({name, " busy during clear wait"}, 32'(busy), 32'd1);
    waitIdle(1'b0, 1000, name);
    checkOutput({name, " clear wait ns"}, 32'($time - t_fall), 32'(10 * CLK_PER));
    checkOutput({name, " log size"}, 32'(log1.size() - lbase), 32'd4);
    checkOutput({name, " cmd0"}, 32'(entryAt(log1, lbase)),     32'h038);
    checkOutput({name, " cmd1"}, 32'(entryAt(log1, lbase + 1)), 32'h00C);
    checkOutput({name, " cmd2"}, 32'(entryAt(log1, lbase + 2)), 32'h006);
    checkOutput({name, " cmd3"}, 32'(entryAt(log1, lbase + 3)), 32'h001);
    checkOutput({name, " no done"}, 32'(done_cnt - dbase), 32'd0);
  endtask

  initial begin
    int lb, db, n;

    vecs[0] = '{32'd1234,       32'hFFFF_FFFB, "       1234", "         -5"};
    vecs[1] = '{32'd0,          32'h8000_0000, "          0", "-2147483648"};
    vecs[2] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF, " 2147483647", "         -1"};
    vecs[3] = '{32'hC465_3600,  32'd42,        "-1000000000", "         42"};

    vecs2[0] = '{32'hFFFF_FC18, "####"};
    vecs2[1] = '{32'd999,       " 999"};
    vecs2[2] = '{32'hFFFF_FC19, "-999"};
    vecs2[3] = '{32'd1000,      "1000"};
    vecs2[4] = '{32'd0,         "   0"};
    vecs2[5] = '{32'd12345,     "####"};

    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    value_a = '0; value_b = '0; value_a2 = '0; value_b2 = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset and power-up init");
    checkOutput("reset bus", {20'd0, lcd_data, lcd_rs, lcd_rw, lcd_e}, 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd1);
    checkOutput("reset busy dut2", 32'(busy2), 32'd1);
    lb = log1.size();
    db = done_cnt;
    rst = 1'b0;
    runInit("init", lb, db);
    waitIdle(1'b1, 1000, "dut2 init");

    $display("[TB] two-line vectors, FIELD_W=11");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, vecs[i].a, vecs[i].b, lb, db);
      checkUpdate($sformatf("vec%0d", i), lb, db, vecs[i].l1, vecs[i].l2);
    end

    $display("[TB] one-line vectors, FIELD_W=4");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs2[i].a, 32'd0, lb, db);
      checkOutput($sformatf("w4 vec%0d log size", i), 32'(log2.size() - lb), 32'd5);
      checkOutput($sformatf("w4 vec%0d addr", i), 32'(entryAt(log2, lb)), 32'h080);
      checkText($sformatf("w4 vec%0d line1", i), lineText(log2, lb + 1, 4), vecs2[i].l1);
      checkOutput($sformatf("w4 vec%0d done pulses", i), 32'(done_cnt2 - db), 32'd1);
    end

    $display("[TB] start while busy is ignored");
    waitIdle(1'b0, 3000, "mid-start pre");
    @(negedge clk);
    lb = log1.size();
    db = done_cnt;
    value_a = 32'd111; value_b = 32'd222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    value_a = 32'd333; value_b = 32'd444; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2500) @(negedge clk);
    checkUpdate("mid-start", lb, db, "        111", "        222");
    checkOutput("mid-start idle after", 32'(busy), 32'd0);

    $display("[TB] reset during CHARS");
    waitIdle(1'b0, 3000, "abort pre");
    @(negedge clk);
    lb = log1.size();
    value_a = 32'd77; value_b = 32'd88; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (log1.size() - lb < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort reached CHARS", 32'(log1.size() - lb >= 3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort bus", {20'd0, lcd_data, lcd_rs, lcd_rw, lcd_e}, 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd1);
    checkOutput("abort done", 32'(done), 32'd0);
    lb = log1.size();
    db = done_cnt;
    rst = 1'b0;
    runInit("reinit", lb, db);
    applyStimulus(1'b0, vecs[0].a, vecs[0].b, lb, db);
    checkUpdate("recover", lb, db, vecs[0].l1, vecs[0].l2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
